// File: rtl/spike_dispatch_queue.sv
// spike_dispatch_queue: collects per-lane spike events, arbitrates them
// round-robin into a first-word-fall-through packet queue and presents the
// oldest packet to a valid/ready consumer.
module spike_dispatch_queue #(
    parameter int NUM_LANES  = 10,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [NUM_LANES-1:0]          src_valid,
    input  logic [NUM_LANES*ADDR_W-1:0]   src_addr,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [3:0]                    pkt_dest,
    output logic [ADDR_W-1:0]             pkt_source,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CAND_W = LANE_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Per-lane event holding registers
    logic [NUM_LANES-1:0] pending;
    logic [ADDR_W-1:0]    lane_addr [NUM_LANES];
    logic [LANE_W-1:0]    rr_ptr;

    // Packet queue storage and bookkeeping
    logic [3:0]           fifo_dest [FIFO_DEPTH];
    logic [ADDR_W-1:0]    fifo_src  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    // Cycle-level control
    logic                 pop;
    logic                 fifo_full;
    logic                 grant_any;
    logic [LANE_W-1:0]    grant_idx;
    logic [CAND_W-1:0]    cand;
    logic [NUM_LANES-1:0] grant_vec;
    logic [NUM_LANES-1:0] capture_vec;
    logic [NUM_LANES-1:0] drop_vec;

    assign pkt_valid  = (count != '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = pkt_valid & pkt_ready & ~clear;
    assign pkt_dest   = fifo_dest[rd_ptr];
    assign pkt_source = fifo_src[rd_ptr];
    assign fifo_count = count;
    assign busy       = (|pending) | pkt_valid;

    // Round-robin search: first pending lane at or after rr_ptr, with space in the queue
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_LANES)) begin
                cand = cand - CAND_W'(NUM_LANES);
            end
            if (pending[cand[LANE_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[LANE_W-1:0];
            end
        end
        if (clear || (fifo_full && !pop)) begin
            grant_any = 1'b0;
        end
    end

    // Decode which lanes capture a new address and which drop one this cycle
    always_comb begin
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
        capture_vec = src_valid & (~pending | grant_vec) & {NUM_LANES{~clear}};
        drop_vec    = src_valid & pending & ~grant_vec & {NUM_LANES{~clear}};
    end

    // Lane pending bits, sticky overflow flag and round-robin pointer
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
            rr_ptr   <= '0;
        end else if (clear) begin
            pending  <= '0;
            overflow <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            pending  <= (pending & ~grant_vec) | capture_vec;
            overflow <= overflow | (|drop_vec);
            if (grant_any) begin
                rr_ptr <= (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Lane address capture; contents are only meaningful while the lane is pending
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (capture_vec[i]) begin
                lane_addr[i] <= src_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count alone
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant_any) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_any, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage write of the granted lane's index and held address
    always_ff @(posedge CLK) begin
        if (grant_any) begin
            fifo_dest[wr_ptr] <= 4'(grant_idx);
            fifo_src[wr_ptr]  <= lane_addr[grant_idx];
        end
    end

endmodule

// File: doc/spike_dispatch_queue.md
SPIKE_DISPATCH_QUEUE -- requirements
Module: spike_dispatch_queue

Interface
REQ-001 Parameters SHALL be: NUM_LANES, default 10, number of destination lanes; ADDR_W, default 12, source-address width; FIFO_DEPTH, default 8, packet queue depth (power of 2).
REQ-002 There SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous timestep flush
- src_valid  in  NUM_LANES  bit i = new source address on lane i this cycle
- src_addr  in  NUM_LANES*ADDR_W  lane i address at bits [ADDR_W*i+ADDR_W-1 : ADDR_W*i]
- pkt_valid  out  1  head packet available
- pkt_ready  in  1  consumer accepts head packet
- pkt_dest  out  4  destination lane index of head packet
- pkt_source  out  ADDR_W  source neuron address of head packet
- fifo_count  out  log2(FIFO_DEPTH)+1  packets currently queued
- overflow  out  1  sticky flag, a lane event was dropped
- busy  out  1  any lane pending or FIFO non-empty

Function
REQ-004 Each lane SHALL own a pending bit and an ADDR_W address register.
REQ-005 When src_valid[i]=1 and clear=0, lane i SHALL set pending[i]=1 and capture its src_addr slice at that edge.
REQ-006 If src_valid[i]=1 while pending[i]=1 and lane i is not granted that cycle, the new address SHALL be dropped, the held address kept, and overflow set to 1.
REQ-007 If src_valid[i]=1 in the same cycle lane i is granted, the granted (old) address SHALL be pushed and the new address SHALL be captured, with pending[i] remaining 1; overflow SHALL not be set.
REQ-008 The arbiter SHALL grant at most one lane per cycle: the lowest-indexed pending lane at or after rr_ptr, wrapping from NUM_LANES-1 to 0.
REQ-009 A grant SHALL occur only when fifo_count<FIFO_DEPTH, or fifo_count==FIFO_DEPTH with a pop in the same cycle.
REQ-010 On grant, {lane index, lane address} SHALL be pushed into the FIFO, pending[lane] cleared (unless REQ-007 applies), and rr_ptr set to (lane+1) mod NUM_LANES.
REQ-011 With no grant, rr_ptr SHALL hold.
REQ-012 The FIFO SHALL be first-word-fall-through: pkt_valid=(fifo_count!=0), and pkt_dest/pkt_source SHALL show the oldest entry combinationally from the FIFO storage.
REQ-013 A pop SHALL occur when pkt_valid=1 and pkt_ready=1; pkt_dest/pkt_source SHALL be held stable while pkt_valid=1 and pkt_ready=0.
REQ-014 fifo_count SHALL update by +1 on push only, -1 on pop only, and SHALL be unchanged on simultaneous push and pop.
REQ-015 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 Minimum latency SHALL be 2 edges: src_valid sampled at edge N, pushed at edge N+1, pkt_valid=1 after edge N+1.
REQ-017 busy SHALL equal (|pending) OR (fifo_count!=0).
REQ-018 When clear=1 at an edge, the block SHALL zero all pending bits, fifo_count, FIFO pointers, rr_ptr and overflow; src_valid and pkt_ready SHALL be ignored that cycle and no push or pop SHALL occur.

Reset
REQ-019 While reset=1, independent of CLK, the block SHALL drive pending=0, rr_ptr=0, FIFO pointers=0, fifo_count=0, overflow=0, pkt_valid=0 and busy=0.
REQ-020 Lane address registers and FIFO storage need not be reset; pkt_dest/pkt_source SHALL be don't-care while pkt_valid=0.
REQ-021 Reset asserted mid-operation SHALL discard all queued and pending events; the first edge after deassertion SHALL behave as after power-up.

Verification
REQ-022 Lane 3 src_valid pulse with addr 0x005 and pkt_ready=1 -> pkt_valid high after the 2nd edge with pkt_dest=3, pkt_source=0x005, then low the next cycle.
REQ-023 Lanes 3, 5 and 7 pulsed together (addr 0x000), pkt_ready=1, rr_ptr=0 -> packets are output in the order dest 3, 5, 7 on consecutive cycles, with rr_ptr=8 afterwards.
REQ-024 pkt_ready=0 and all 10 lanes pulsed with addr=lane -> fifo_count saturates at 8, lanes 8 and 9 stay pending with busy=1, overflow stays 0; then pkt_ready=1 -> all 10 packets are delivered with no loss.
REQ-025 Lane 8 pulsed on two consecutive cycles while blocked (FIFO full) with addrs 0x003 then 0x004 -> overflow=1, and the later delivered lane-8 packet carries 0x003.
REQ-026 Full FIFO with pkt_ready=1 and a pending lane -> simultaneous pop and push occur and fifo_count stays at 8.
REQ-027 clear asserted with 4 packets queued and 2 lanes pending -> next cycle fifo_count=0, busy=0, pkt_valid=0 and overflow=0; asynchronous reset mid-burst gives the same result immediately.
